// File: rtl/mem_port_arbiter.sv
// Fetch/data arbiter in front of the unified memory: one access per cycle,
// registered responses, fetch anti-starvation and bounded data-port locking.
//
// state  | meaning
// ARB    | normal arbitration between fetch and data ports
// LOCKED | data port holds the memory for an atomic sequence
module mem_port_arbiter #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter int MEM_DEPTH = 1024,
  parameter int MAX_WAIT  = 4,
  parameter int LOCK_MAX  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic              d_lock,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam int LW = $clog2(LOCK_MAX + 1);
  localparam logic [WW-1:0]   WAIT_SAT = WW'(MAX_WAIT);
  localparam logic [LW-1:0]   LOCK_TOP = LW'(LOCK_MAX);
  localparam logic [ADDR_W:0] DEPTH_X  = (ADDR_W+1)'(MEM_DEPTH);

  typedef enum logic {ARB, LOCKED} state_t;

  state_t          state, state_nx;
  logic [WW-1:0]   wait_cnt, wait_cnt_nx;
  logic [LW-1:0]   lock_cnt, lock_cnt_nx, lock_inc;
  logic            force_fetch, force_fetch_nx;
  logic            i_in_range, d_in_range;

  assign i_in_range = ({1'b0, i_addr} < DEPTH_X);
  assign d_in_range = ({1'b0, d_addr} < DEPTH_X);
  assign lock_inc   = lock_cnt + 1'b1;

  always_comb begin
    i_gnt          = 1'b0;
    d_gnt          = 1'b0;
    state_nx       = state;
    lock_cnt_nx    = lock_cnt;
    force_fetch_nx = 1'b0;
    if (state == ARB) begin
      if ((wait_cnt == WAIT_SAT || force_fetch) && i_req) i_gnt = 1'b1;
      else if (d_req)                                      d_gnt = 1'b1;
      else if (i_req)                                      i_gnt = 1'b1;
      if (d_gnt && d_lock) begin
        if (LOCK_MAX <= 1) begin
          force_fetch_nx = 1'b1;
          lock_cnt_nx    = '0;
        end else begin
          state_nx    = LOCKED;
          lock_cnt_nx = LW'(1);
        end
      end
    end else begin
      d_gnt = d_req;
      if (!d_req || !d_lock) begin
        state_nx    = ARB;
        lock_cnt_nx = '0;
      end else if (lock_inc >= LOCK_TOP) begin
        // lock budget spent: hand the next ARB cycle to fetch
        state_nx       = ARB;
        lock_cnt_nx    = '0;
        force_fetch_nx = 1'b1;
      end else begin
        lock_cnt_nx = lock_inc;
      end
    end
    if (!rst_n) begin
      i_gnt = 1'b0;
      d_gnt = 1'b0;
    end
  end

  always_comb begin
    wait_cnt_nx = wait_cnt;
    if (!i_req || i_gnt)        wait_cnt_nx = '0;
    else if (wait_cnt != WAIT_SAT) wait_cnt_nx = wait_cnt + 1'b1;
  end

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    if (d_gnt) begin
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
      mem_we    = d_we & d_in_range;
      mem_re    = ~d_we & d_in_range;
    end else if (i_gnt) begin
      mem_addr = i_addr;
      mem_re   = i_in_range;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ARB;
      wait_cnt    <= '0;
      lock_cnt    <= '0;
      force_fetch <= 1'b0;
      i_rvalid    <= 1'b0;
      i_rdata     <= '0;
      i_err       <= 1'b0;
      d_rvalid    <= 1'b0;
      d_rdata     <= '0;
      d_err       <= 1'b0;
    end else begin
      state       <= state_nx;
      wait_cnt    <= wait_cnt_nx;
      lock_cnt    <= lock_cnt_nx;
      force_fetch <= force_fetch_nx;
      i_rvalid    <= i_gnt;
      i_rdata     <= (i_gnt && i_in_range) ? mem_rdata : '0;
      i_err       <= i_gnt && !i_in_range;
      d_rvalid    <= d_gnt;
      d_rdata     <= (d_gnt && !d_we && d_in_range) ? mem_rdata : '0;
      d_err       <= d_gnt && !d_in_range;
    end
  end

endmodule
